galaga_clk_rst: RTL and testbench

Clock-enable and reset sequencer placed directly downstream of the 36 MHz Gowin rPLL (27 MHz × 12/9). It consumes the PLL output clock and LOCK. It debounces LOCK, then releases the Galaga core reset only after lock has been continuously stable and a hold period has elapsed. It also generates phase-aligned clock-enable pulses for the CPU (18 MHz) and pixel (6 MHz) domains, so the whole core runs on the single PLL clock.

---
 rtl/galaga_clk_rst_pkg.sv | 26 ++
 rtl/galaga_clk_rst_lock_sync.sv | 25 ++
 rtl/galaga_clk_rst.sv | 150 +++++++++++++++
 tb/tb_galaga_clk_rst.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/galaga_clk_rst_pkg.sv
// galaga_clk_rst_pkg: shared types and defaults for the clock-enable/reset sequencer.
// Holds the sequencer state enum, default timing constants and small helpers.
package galaga_clk_rst_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_HOLD_CYCLES   = 16;
    localparam int DEF_CPU_DIV       = 2;
    localparam int DEF_PIX_DIV       = 6;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Dividers only run while the core clock domain is live.
    function automatic logic is_active(input state_t s);
        return (s == HOLD) || (s == RUN);
    endfunction

endpackage

// File: rtl/galaga_clk_rst_lock_sync.sv
// lock_sync: generic 2-flop synchronizer with asynchronous active-low clear.
// Ports: i_clk, i_rst_n (async clear), i_async (raw input), o_sync (synchronized).
module lock_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/galaga_clk_rst.sv
// galaga_clk_rst: lock-qualified core reset sequencer plus CPU/pixel clock enables.
// Ports: clk, reset_n (async), pll_lock (async) in; core_reset_n, ce_cpu, ce_pix,
// ready, lock_lost out. Macro LOCK_LOSS_RESET_EN re-arms the sequence on lock loss.
module galaga_clk_rst
    import galaga_clk_rst_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int CPU_DIV       = DEF_CPU_DIV,
    parameter int PIX_DIV       = DEF_PIX_DIV
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pll_lock,
    output logic core_reset_n,
    output logic ce_cpu,
    output logic ce_pix,
    output logic ready,
    output logic lock_lost
);

    localparam int CW    = $clog2(max_int(STABLE_CYCLES, HOLD_CYCLES) + 1);
    localparam int CPU_W = $clog2(CPU_DIV);
    localparam int PIX_W = $clog2(PIX_DIV);

    localparam logic [CW-1:0]    STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0]    HOLD_LAST   = CW'(HOLD_CYCLES - 1);
    localparam logic [CPU_W-1:0] CPU_LAST    = CPU_W'(CPU_DIV - 1);
    localparam logic [PIX_W-1:0] PIX_LAST    = PIX_W'(PIX_DIV - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [CPU_W-1:0] r_cpu_cnt;
    logic [CPU_W-1:0] w_cpu_nxt;
    logic [PIX_W-1:0] r_pix_cnt;
    logic [PIX_W-1:0] w_pix_nxt;
    logic             r_ce_cpu;
    logic             r_ce_pix;
    logic             r_core_rst_n;
    logic             r_ready;
    logic             r_lock_lost;
    logic             w_lock_s;
    logic             w_drop;
    logic             w_div_run;

    lock_sync u_lock_sync (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_async (pll_lock),
        .o_sync  (w_lock_s)
    );

`ifdef LOCK_LOSS_RESET_EN
    assign w_drop = !w_lock_s;
`else
    assign w_drop = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            WAIT_LOCK: begin
                w_cnt_nxt = '0;
                if (w_lock_s) begin
                    w_state_nxt = STABLE;
                end
            end
            STABLE: begin
                // A drop on the completion edge still wins.
                if (!w_lock_s) begin
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == STABLE_LAST) begin
                    w_state_nxt = HOLD;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            HOLD: begin
                if (w_drop) begin
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == HOLD_LAST) begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            RUN: begin
                w_cnt_nxt = '0;
                if (w_drop) begin
                    w_state_nxt = WAIT_LOCK;
                end
            end
            default: begin
                w_state_nxt = WAIT_LOCK;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Both dividers restart from 0 on HOLD entry and clear on the exit edge,
    // so the pixel enable always lands on a CPU enable.
    assign w_div_run = is_active(r_state) && is_active(w_state_nxt);

    always_comb begin
        w_cpu_nxt = '0;
        w_pix_nxt = '0;
        if (w_div_run) begin
            w_cpu_nxt = (r_cpu_cnt == CPU_LAST) ? '0 : r_cpu_cnt + CPU_W'(1);
            w_pix_nxt = (r_pix_cnt == PIX_LAST) ? '0 : r_pix_cnt + PIX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= WAIT_LOCK;
            r_cnt        <= '0;
            r_cpu_cnt    <= '0;
            r_pix_cnt    <= '0;
            r_ce_cpu     <= 1'b0;
            r_ce_pix     <= 1'b0;
            r_core_rst_n <= 1'b0;
            r_ready      <= 1'b0;
            r_lock_lost  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_cpu_cnt    <= w_cpu_nxt;
            r_pix_cnt    <= w_pix_nxt;
            r_ce_cpu     <= (w_cpu_nxt == CPU_LAST);
            r_ce_pix     <= (w_pix_nxt == PIX_LAST);
            r_core_rst_n <= (w_state_nxt == RUN);
            r_ready      <= (w_state_nxt == RUN);
            r_lock_lost  <= r_lock_lost | (is_active(r_state) & w_drop);
        end
    end

    assign core_reset_n = r_core_rst_n;
    assign ready        = r_ready;
    assign ce_cpu       = r_ce_cpu;
    assign ce_pix       = r_ce_pix;
    assign lock_lost    = r_lock_lost;

endmodule

// File: tb/tb_galaga_clk_rst.sv
// tb_galaga_clk_rst: directed bench for galaga_clk_rst (STABLE=8, HOLD=4).
// Lock-loss expectations follow LOCK_LOSS_RESET_EN as compiled.
module tb_galaga_clk_rst;

    localparam int S   = 8;
    localparam int H   = 4;
    localparam int SEQ = 2 + S + H;

    logic clk      = 1'b0;
    logic reset_n  = 1'b0;
    logic pll_lock = 1'b0;
    logic core_reset_n;
    logic ce_cpu;
    logic ce_pix;
    logic ready;
    logic lock_lost;

    int n_chk = 0;
    int n_err = 0;
    int ec    = 0;
    int t0    = 0;
    int h0    = 0;

    always #5 clk = ~clk;

    galaga_clk_rst #(
        .STABLE_CYCLES (S),
        .HOLD_CYCLES   (H),
        .CPU_DIV       (2),
        .PIX_DIV       (6)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pll_lock     (pll_lock),
        .core_reset_n (core_reset_n),
        .ce_cpu       (ce_cpu),
        .ce_pix       (ce_pix),
        .ready        (ready),
        .lock_lost    (lock_lost)
    );

    task automatic tick();
        @(posedge clk);
        ec++;
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Next posedge becomes relative edge 0; HOLD is entered at edge 2+S.
    task automatic arm();
        t0 = ec + 1;
        h0 = t0 + 2 + S;
    endtask

    task automatic chk_ce(input string tag);
        chk({tag, "_cpu"}, ce_cpu, logic'((ec - h0) % 2 == 1));
        chk({tag, "_pix"}, ce_pix, logic'((ec - h0) % 6 == 5));
        chk({tag, "_pix_in_cpu"}, ce_pix & ~ce_cpu, 1'b0);
    endtask

    initial begin
        pll_lock = 1'b1;
        reset_n  = 1'b0;
        ticks(3);
        chk("rst_core", core_reset_n, 1'b0);
        chk("rst_ready", ready, 1'b0);
        chk("rst_cecpu", ce_cpu, 1'b0);
        chk("rst_cepix", ce_pix, 1'b0);
        chk("rst_lost", lock_lost, 1'b0);

        reset_n = 1'b1;
        arm();
        ticks(11);
        chk("hold_cecpu0", ce_cpu, 1'b0);
        tick();
        chk("hold_cecpu1", ce_cpu, 1'b1);
        ticks(2);
        chk("seq_core13", core_reset_n, 1'b0);
        chk("seq_ready13", ready, 1'b0);
        tick();
        chk("seq_core14", core_reset_n, 1'b1);
        chk("seq_ready14", ready, 1'b1);
        chk("seq_cecpu14", ce_cpu, 1'b0);
        chk("seq_cepix14", ce_pix, 1'b0);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk_ce("run");
        end

        pll_lock = 1'b0;
        ticks(2);
        chk("drop_core2", core_reset_n, 1'b1);
        tick();
`ifdef LOCK_LOSS_RESET_EN
        chk("drop_core3", core_reset_n, 1'b0);
        chk("drop_ready3", ready, 1'b0);
        chk("drop_cecpu3", ce_cpu, 1'b0);
        chk("drop_cepix3", ce_pix, 1'b0);
        chk("drop_lost3", lock_lost, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("drop_cecpu", ce_cpu, 1'b0);
            chk("drop_cepix", ce_pix, 1'b0);
        end
        pll_lock = 1'b1;
        arm();
        ticks(SEQ);
        chk("relock_core13", core_reset_n, 1'b0);
        chk("relock_lost13", lock_lost, 1'b1);
        tick();
        chk("relock_core14", core_reset_n, 1'b1);
        chk("relock_ready14", ready, 1'b1);
        chk("relock_lost14", lock_lost, 1'b1);
`else
        for (int i = 0; i < 10; i++) begin
            chk("nodrop_core", core_reset_n, 1'b1);
            chk("nodrop_lost", lock_lost, 1'b0);
            chk_ce("nodrop");
            tick();
        end
        pll_lock = 1'b1;
`endif

        reset_n = 1'b0;
        tick();
        chk("rst2_lost", lock_lost, 1'b0);
        reset_n = 1'b1;
        arm();
        ticks(8);
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        arm();
        ticks(6);
        chk("glitch_core5", core_reset_n, 1'b0);
        ticks(8);
        chk("glitch_core13", core_reset_n, 1'b0);
        chk("glitch_lost", lock_lost, 1'b0);
        tick();
        chk("glitch_core14", core_reset_n, 1'b1);
        chk("glitch_ready14", ready, 1'b1);

        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        arm();
        ticks(14);
        chk("midhold_cecpu_pre", ce_cpu, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_core", core_reset_n, 1'b0);
        chk("async_ready", ready, 1'b0);
        chk("async_cecpu", ce_cpu, 1'b0);
        chk("async_cepix", ce_pix, 1'b0);
        chk("async_lost", lock_lost, 1'b0);
        tick();
        reset_n = 1'b1;
        arm();
        ticks(SEQ);
        chk("restart_core13", core_reset_n, 1'b0);
        tick();
        chk("restart_core14", core_reset_n, 1'b1);
        chk("restart_ready14", ready, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
